// File: rtl/prog_delay_line_if.sv
// Bundle of config, input stream and delayed output stream for prog_delay_line.
// Latency: none, wires only.
// Backpressure: none; clk_en is the single advance qualifier for the whole block.
interface prog_delay_line_if #(
  parameter int DW    = 16,
  parameter int CH    = 4,
  parameter int MAX_L = 32
) ();
  localparam int LW = $clog2(MAX_L + 1);

  logic                   clk_en;
  logic                   cfg_load;
  logic [LW-1:0]          cfg_len;
  logic                   s_valid;
  logic [CH-1:0][DW-1:0]  s_data;
  logic                   d_valid;
  logic [CH-1:0][DW-1:0]  d_data;
  logic                   busy;
  logic [LW-1:0]          len_cur;

  // Producer/consumer side: drives stream and config, observes delayed stream.
  modport master (
    output clk_en, cfg_load, cfg_len, s_valid, s_data,
    input  d_valid, d_data, busy, len_cur
  );

  // Delay line side.
  modport slave (
    input  clk_en, cfg_load, cfg_len, s_valid, s_data,
    output d_valid, d_data, busy, len_cur
  );
endinterface

// File: rtl/prog_delay_line.sv
// Runtime-programmable multi-channel delay line built on a circular buffer.
// Latency: len_cur enabled clocks from s_* to d_*; the read port is combinational off storage.
// Backpressure: none; clk_en freezes everything except cfg_load. Macro DELAY_MASK_INVALID_EN zeroes d_data while invalid.
module prog_delay_line #(
  parameter int DW     = 16,
  parameter int CH     = 4,
  parameter int MAX_L  = 32,
  parameter int INIT_L = 4
) (
  input  logic              clk,
  input  logic              rst,
  prog_delay_line_if.slave  io
);
  localparam int LW = $clog2(MAX_L + 1);
  localparam int PW = (MAX_L > 1) ? $clog2(MAX_L) : 1;

  typedef logic [CH-1:0][DW-1:0] dat_t;
  typedef enum logic {FILL, RUN} state_t;

  dat_t             data_mem_q [MAX_L];
  logic [MAX_L-1:0] vld_q, vld_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    fill_q, fill_d;
  state_t           state_q, state_d;
  logic [LW-1:0]    len_clamp;
  logic [LW-1:0]    wptr_w;
  logic [LW-1:0]    rd_w;
  logic [PW-1:0]    rd_idx;

  // Requested delay forced into the legal 1..MAX_L range.
  always_comb begin
    len_clamp = io.cfg_len;
    if (io.cfg_len == '0) begin
      len_clamp = LW'(1);
    end else if (io.cfg_len > LW'(MAX_L)) begin
      len_clamp = LW'(MAX_L);
    end
  end

  // Next-state for tags, write pointer, active length, fill counter and refill state.
  always_comb begin
    vld_d  = vld_q;
    wptr_d = wptr_q;
    len_d  = len_q;
    fill_d = fill_q;
    if (io.cfg_load) begin
      // Old tags no longer line up with the new length; data itself can stay.
      vld_d  = '0;
      len_d  = len_clamp;
      fill_d = io.clk_en ? LW'(1) : '0;
    end else if (io.clk_en && (fill_q < LW'(MAX_L))) begin
      fill_d = fill_q + LW'(1);
    end
    if (io.clk_en) begin
      // Applied after the clear so a coinciding write keeps its own tag.
      vld_d[wptr_q] = io.s_valid;
      wptr_d = (wptr_q == PW'(MAX_L - 1)) ? '0 : wptr_q + PW'(1);
    end
    // Evaluated on the new values so len=1 with a same-edge write leaves FILL immediately.
    state_d = (fill_d >= len_d) ? RUN : FILL;
  end

  // Control registers and refill FSM; reset wins over cfg_load and clk_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      wptr_q  <= '0;
      len_q   <= LW'(INIT_L);
      fill_q  <= '0;
      state_q <= FILL;
    end else begin
      vld_q   <= vld_d;
      wptr_q  <= wptr_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      state_q <= state_d;
    end
  end

  // Data storage: plain write port, no reset, so it can map onto a RAM.
  always_ff @(posedge clk) begin
    if (!rst && io.clk_en) begin
      data_mem_q[wptr_q] <= io.s_data;
    end
  end

  // Read slot is (wptr - len) mod MAX_L; len=MAX_L reads the slot about to be overwritten.
  always_comb begin
    wptr_w = LW'(wptr_q);
    if (wptr_w >= len_q) begin
      rd_w = wptr_w - len_q;
    end else begin
      rd_w = wptr_w + LW'(MAX_L) - len_q;
    end
    rd_idx = PW'(rd_w);
  end

  assign io.d_valid = vld_q[rd_idx];
  assign io.busy    = (state_q == FILL);
  assign io.len_cur = len_q;

`ifdef DELAY_MASK_INVALID_EN
  assign io.d_data = vld_q[rd_idx] ? data_mem_q[rd_idx] : '0;
`else
  assign io.d_data = data_mem_q[rd_idx];
`endif

endmodule

// File: tb/tb_prog_delay_line.sv
// Self-checking bench for prog_delay_line: scoreboard of expected outputs keyed by enabled-edge count.
// Latency: checks every cycle, 1 time unit after the rising edge.
// Backpressure: exercised through clk_en gaps and cfg_load flushes.
module tb_prog_delay_line;
  localparam int DW     = 16;
  localparam int CH     = 4;
  localparam int MAX_L  = 32;
  localparam int INIT_L = 4;
  localparam int LW     = $clog2(MAX_L + 1);

  typedef logic [CH-1:0][DW-1:0] dat_t;
  typedef struct {
    dat_t d;
    int   due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_delay_line_if #(.DW(DW), .CH(CH), .MAX_L(MAX_L)) io ();

  prog_delay_line #(.DW(DW), .CH(CH), .MAX_L(MAX_L), .INIT_L(INIT_L)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  int   en_cnt = 0;
  int   fill_m = 0;
  int   len_m  = INIT_L;
  logic exp_v  = 1'b0;
  dat_t exp_d  = '0;

  function automatic dat_t mk(input int v);
    dat_t r;
    for (int c = 0; c < CH; c++) r[c] = DW'(v + c * 4096);
    return r;
  endfunction

  function automatic int clampf(input int l);
    if (l == 0) return 1;
    if (l > MAX_L) return MAX_L;
    return l;
  endfunction

  // One clock: drive inputs, take the edge, advance the reference model.
  task automatic cycle(input logic r, input logic en, input logic vld, input int v,
                       input logic ld, input int l);
    rst         = r;
    io.clk_en   = en;
    io.s_valid  = vld;
    io.s_data   = mk(v);
    io.cfg_load = ld;
    io.cfg_len  = LW'(l);
    @(posedge clk);
    #1;
    if (r) begin
      sb.delete();
      len_m  = INIT_L;
      fill_m = 0;
      exp_v  = 1'b0;
    end else begin
      if (ld) begin
        sb.delete();
        len_m  = clampf(l);
        fill_m = en ? 1 : 0;
        exp_v  = 1'b0;
      end else if (en && fill_m < MAX_L) begin
        fill_m++;
      end
      if (en) begin
        en_cnt++;
        if (vld) sb.push_back('{mk(v), en_cnt + len_m - 1});
        if (sb.size() > 0 && sb[0].due == en_cnt) begin
          exp_v = 1'b1;
          exp_d = sb[0].d;
          void'(sb.pop_front());
        end else begin
          exp_v = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    total++; if (io.d_valid !== 1'b0) begin bad++; $display("FAIL reset_dvalid got=%b exp=0", io.d_valid); end
    total++; if (io.busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", io.busy); end
    total++; if (io.len_cur !== LW'(INIT_L)) begin bad++; $display("FAIL reset_len got=%0d exp=%0d", io.len_cur, INIT_L); end
`ifdef DELAY_MASK_INVALID_EN
    total++; if (io.d_data !== '0) begin bad++; $display("FAIL reset_ddata got=%h exp=0", io.d_data); end
`endif
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b0, 1'b1, 1'b1, i, 1'b0, 0);
      if (i == 3) begin
        total++; if (io.d_valid !== 1'b0 || io.busy !== 1'b1) begin bad++; $display("FAIL stream_edge3 vld=%b busy=%b exp vld=0 busy=1", io.d_valid, io.busy); end
      end
      if (i == 4) begin
        total++; if (io.d_valid !== 1'b1 || io.d_data[0] !== 16'd1 || io.busy !== 1'b0) begin bad++; $display("FAIL stream_edge4 vld=%b d0=%0d busy=%b exp vld=1 d0=1 busy=0", io.d_valid, io.d_data[0], io.busy); end
      end
      total++; if (io.d_valid !== exp_v) begin bad++; $display("FAIL stream_vld i=%0d got=%b exp=%b", i, io.d_valid, exp_v); end
      if (exp_v) begin total++; if (io.d_data !== exp_d) begin bad++; $display("FAIL stream_data i=%0d got=%h exp=%h", i, io.d_data, exp_d); end end
      total++; if (io.busy !== (fill_m < len_m)) begin bad++; $display("FAIL stream_busy i=%0d got=%b exp=%b", i, io.busy, fill_m < len_m); end
    end
  endtask

  task automatic test_clk_en();
    cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, 4);
    total++; if (io.d_valid !== 1'b0 || io.busy !== 1'b1) begin bad++; $display("FAIL clken_load vld=%b busy=%b exp vld=0 busy=1", io.d_valid, io.busy); end
    for (int i = 0; i < 24; i++) begin
      cycle(1'b0, (i % 2) == 0, 1'b1, 100 + i, 1'b0, 0);
      total++; if (io.d_valid !== exp_v) begin bad++; $display("FAIL clken_vld i=%0d got=%b exp=%b", i, io.d_valid, exp_v); end
      if (exp_v) begin total++; if (io.d_data !== exp_d) begin bad++; $display("FAIL clken_data i=%0d got=%h exp=%h", i, io.d_data, exp_d); end end
      total++; if (io.busy !== (fill_m < len_m)) begin bad++; $display("FAIL clken_busy i=%0d got=%b exp=%b", i, io.busy, fill_m < len_m); end
    end
  endtask

  task automatic test_len1();
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b1, 200 + i, 1'b0, 0);
    cycle(1'b0, 1'b1, 1'b1, 555, 1'b1, 1);
    total++; if (io.d_valid !== 1'b1) begin bad++; $display("FAIL len1_vld got=%b exp=1", io.d_valid); end
    total++; if (io.d_data !== mk(555)) begin bad++; $display("FAIL len1_data got=%h exp=%h", io.d_data, mk(555)); end
    total++; if (io.busy !== 1'b0) begin bad++; $display("FAIL len1_busy got=%b exp=0", io.busy); end
    total++; if (io.len_cur !== LW'(1)) begin bad++; $display("FAIL len1_len got=%0d exp=1", io.len_cur); end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 600 + i, 1'b0, 0);
      total++; if (io.d_valid !== 1'b1 || io.d_data !== mk(600 + i)) begin bad++; $display("FAIL len1_stream i=%0d vld=%b got=%h exp=%h", i, io.d_valid, io.d_data, mk(600 + i)); end
    end
  endtask

  task automatic test_len32();
    cycle(1'b0, 1'b1, 1'b1, 0, 1'b1, 32);
    for (int i = 1; i < 100; i++) begin
      cycle(1'b0, 1'b1, 1'b1, i, 1'b0, 0);
      if (i == 30) begin
        total++; if (io.busy !== 1'b1 || io.d_valid !== 1'b0) begin bad++; $display("FAIL len32_fill busy=%b vld=%b exp busy=1 vld=0", io.busy, io.d_valid); end
      end
      if (i >= 31) begin
        total++; if (io.d_data[0] !== 16'(i - 31) || io.busy !== 1'b0) begin bad++; $display("FAIL len32_run i=%0d d0=%0d busy=%b exp d0=%0d busy=0", i, io.d_data[0], io.busy, i - 31); end
      end
      total++; if (io.d_valid !== exp_v) begin bad++; $display("FAIL len32_vld i=%0d got=%b exp=%b", i, io.d_valid, exp_v); end
      if (exp_v) begin total++; if (io.d_data !== exp_d) begin bad++; $display("FAIL len32_data i=%0d got=%h exp=%h", i, io.d_data, exp_d); end end
    end
  endtask

  task automatic test_clamp();
    cycle(1'b0, 1'b1, 1'b1, 700, 1'b1, 0);
    total++; if (io.len_cur !== LW'(1)) begin bad++; $display("FAIL clamp0_len got=%0d exp=1", io.len_cur); end
    for (int i = 1; i < 20; i++) begin
      cycle(1'b0, 1'b1, (i % 3) != 0, 700 + i, 1'b0, 0);
      total++; if (io.d_valid !== exp_v) begin bad++; $display("FAIL clamp1_vld i=%0d got=%b exp=%b", i, io.d_valid, exp_v); end
      if (exp_v) begin total++; if (io.d_data !== exp_d) begin bad++; $display("FAIL clamp1_data i=%0d got=%h exp=%h", i, io.d_data, exp_d); end end
    end
    cycle(1'b0, 1'b1, 1'b1, 800, 1'b1, 40);
    total++; if (io.len_cur !== LW'(32)) begin bad++; $display("FAIL clamp40_len got=%0d exp=32", io.len_cur); end
    for (int i = 1; i < 60; i++) begin
      cycle(1'b0, 1'b1, (i % 5) != 2, 800 + i, 1'b0, 0);
      total++; if (io.d_valid !== exp_v) begin bad++; $display("FAIL clamp32_vld i=%0d got=%b exp=%b", i, io.d_valid, exp_v); end
      if (exp_v) begin total++; if (io.d_data !== exp_d) begin bad++; $display("FAIL clamp32_data i=%0d got=%h exp=%h", i, io.d_data, exp_d); end end
      total++; if (io.busy !== (fill_m < len_m)) begin bad++; $display("FAIL clamp32_busy i=%0d got=%b exp=%b", i, io.busy, fill_m < len_m); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, 900 + i, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b1, 950, 1'b1, 7);
    total++; if (io.d_valid !== 1'b0) begin bad++; $display("FAIL rstmid_vld got=%b exp=0", io.d_valid); end
    total++; if (io.busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy got=%b exp=1", io.busy); end
    total++; if (io.len_cur !== LW'(INIT_L)) begin bad++; $display("FAIL rstmid_len got=%0d exp=%0d", io.len_cur, INIT_L); end
`ifdef DELAY_MASK_INVALID_EN
    total++; if (io.d_data !== '0) begin bad++; $display("FAIL rstmid_data got=%h exp=0", io.d_data); end
`endif
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1000 + i, 1'b0, 0);
      total++; if (io.d_valid !== exp_v) begin bad++; $display("FAIL rstmid_svld i=%0d got=%b exp=%b", i, io.d_valid, exp_v); end
      if (exp_v) begin total++; if (io.d_data !== exp_d) begin bad++; $display("FAIL rstmid_sdata i=%0d got=%h exp=%h", i, io.d_data, exp_d); end end
      total++; if (io.busy !== (fill_m < len_m)) begin bad++; $display("FAIL rstmid_sbusy i=%0d got=%b exp=%b", i, io.busy, fill_m < len_m); end
    end
  endtask

  initial begin
    rst         = 1'b1;
    io.clk_en   = 1'b0;
    io.cfg_load = 1'b0;
    io.cfg_len  = '0;
    io.s_valid  = 1'b0;
    io.s_data   = '0;
    test_reset();
    test_stream();
    test_clk_en();
    test_len1();
    test_len32();
    test_clamp();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
